// File: rtl/mbscore_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mbscore_mem_arbiter_pkg
//   Shared encodings for the MBScore shared-RAM-port arbiter: FSM states,
//   access owner, and a small helper that sizes the internal counters.
//   No ports (package).
// -----------------------------------------------------------------------------
package mbscore_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    // Width that holds values 0..n, used for the latency and streak counters.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mbscore_mem_arbiter_prio.sv
// -----------------------------------------------------------------------------
// mbscore_arb_prio
//   Combinational grant selection for the shared RAM port. The data side wins
//   unless a fetch is pending and the data side has already used up its
//   allowed streak of consecutive grants, in which case the fetch is forced.
// Ports
//   inst_req    in   fetch request pending
//   data_req    in   load/store request pending
//   streak      in   consecutive data grants taken while a fetch waited
//   grant_inst  out  fetch wins this arbitration
//   grant_data  out  data access wins this arbitration
// -----------------------------------------------------------------------------
module mbscore_arb_prio #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int SW              = 3
) (
    input  logic          inst_req,
    input  logic          data_req,
    input  logic [SW-1:0] streak,
    output logic          grant_inst,
    output logic          grant_data
);

    localparam logic [SW-1:0] MAX_S = SW'(MAX_DATA_STREAK);

    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves a value unassigned, which would infer a latch.
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (data_req && !(inst_req && (streak == MAX_S))) begin
            grant_data = 1'b1;
        end else if (inst_req) begin
            grant_inst = 1'b1;
        end
    end

endmodule

// File: rtl/mbscore_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mbscore_mem_arbiter
//   Sequences the single shared RAM port between instruction fetch and data
//   load/store. One access in flight, fixed RAM latency: IDLE -> ACCESS -> RESP.
//   Data has priority; a streak counter forces a fetch grant after
//   MAX_DATA_STREAK consecutive data grants taken while a fetch was pending.
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   inst_req/inst_addr               fetch request and address
//   inst_ack/inst_rdata              one-cycle done pulse, fetched word (held)
//   data_req/data_we/data_addr/
//   data_wdata                       load/store request
//   data_ack/data_rdata              one-cycle done pulse, load word (held)
//   ram_addr/ram_re/ram_we/ram_wdata registered RAM bus outputs
//   ram_rdata                        RAM read data, valid at the last access cycle
// -----------------------------------------------------------------------------
module mbscore_mem_arbiter
    import mbscore_mem_arbiter_pkg::*;
#(
    parameter int RAM_LAT         = 2,
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_ack,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int CW = cnt_width(RAM_LAT);
    localparam int SW = cnt_width(MAX_DATA_STREAK);
    localparam logic [CW-1:0] CNT_INIT = CW'(RAM_LAT - 1);
    localparam logic [SW-1:0] MAX_S    = SW'(MAX_DATA_STREAK);

    state_t        state;
    owner_t        owner;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          grant_inst;
    logic          grant_data;

    mbscore_arb_prio #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK),
        .SW             (SW)
    ) u_prio (
        .inst_req  (inst_req),
        .data_req  (data_req),
        .streak    (streak),
        .grant_inst(grant_inst),
        .grant_data(grant_data)
    );

    // NOTE: all state is assigned with <= so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register is reset, including the held rdata words,
            // so an access aborted by reset leaves no stale data visible.
            state      <= ST_IDLE;
            owner      <= OWNER_INST;
            cnt        <= '0;
            streak     <= '0;
            ram_addr   <= '0;
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            inst_ack   <= 1'b0;
            data_ack   <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            // Acks are single-cycle pulses; only the ACCESS exit raises one.
            inst_ack <= 1'b0;
            data_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!inst_req) begin
                        streak <= '0;
                    end
                    if (grant_data) begin
                        owner     <= OWNER_DATA;
                        ram_addr  <= data_addr;
                        ram_re    <= !data_we;
                        ram_we    <= data_we;
                        ram_wdata <= data_wdata;
                        cnt       <= CNT_INIT;
                        state     <= ST_ACCESS;
                        // Only grants that made a fetch wait count toward the streak.
                        if (inst_req && (streak != MAX_S)) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_inst) begin
                        owner    <= OWNER_INST;
                        ram_addr <= inst_addr;
                        ram_re   <= 1'b1;
                        ram_we   <= 1'b0;
                        cnt      <= CNT_INIT;
                        state    <= ST_ACCESS;
                        streak   <= '0;
                    end
                end

                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // Last access cycle: RAM data is valid now. Stores
                        // (ram_re low) leave the rdata registers untouched.
                        if (ram_re) begin
                            if (owner == OWNER_INST) begin
                                inst_rdata <= ram_rdata;
                            end else begin
                                data_rdata <= ram_rdata;
                            end
                        end
                        ram_re <= 1'b0;
                        ram_we <= 1'b0;
                        if (owner == OWNER_INST) begin
                            inst_ack <= 1'b1;
                        end else begin
                            data_ack <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_RESP: begin
                    // Requests are ignored here so a requester that keeps req
                    // high is not granted while its ack is still visible.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
